cv32e40p_irq_timer: RTL and testbench

//  Memory-mapped interrupt/timer responder on the core data bus; drives the core irq_i vector.

---
 rtl/cv32e40p_irq_timer.sv | 155 +++++++++++++++
 tb/tb_cv32e40p_irq_timer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_irq_timer.sv
// rtl/cv32e40p_irq_timer.sv - memory-mapped mtime/mtimecmp, software and fast IRQ responder driving core irq_i
// Zero-wait-state slave: reads are combinational from the address, writes commit on the clock edge.
module cv32e40p_irq_timer #(
   parameter logic [31:0] BASE_ADDR   = 32'h1A10_0000,
   parameter int unsigned NUM_EXT_IRQ = 16,
   parameter int unsigned MTIME_DIV   = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [31:0]            bus_addr_i,
   input  logic                   bus_we_i,
   input  logic [3:0]             bus_be_i,
   input  logic [31:0]            bus_wdata_i,
   output logic [31:0]            bus_rdata_o,
   output logic                   bus_hit_o,
   input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
   output logic [31:0]            irq_o,
   input  logic                   irq_ack_i,
   input  logic [4:0]             irq_id_i
);

   localparam int unsigned CW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
   localparam int unsigned N  = NUM_EXT_IRQ;

   logic [63:0]   mtime, mtime_nxt;
   logic [63:0]   mtimecmp;
   logic          msip;
   logic          timer_en;
   logic [N-1:0]  pending, pending_nxt;
   logic [N-1:0]  enable;
   logic [N-1:0]  prev;
   logic [N-1:0]  edge_set, clr, ack_mask;
   logic [CW-1:0] presc;
   logic          tick;
   logic [5:0]    offset;
   logic          wr;
   logic [31:0]   lane_mask;
   logic [31:0]   enable_w;
   logic          unused_addr;

   assign bus_hit_o   = (bus_addr_i[31:8] == BASE_ADDR[31:8]);
   assign offset      = bus_addr_i[7:2];
   assign wr          = bus_hit_o & bus_we_i;
   assign unused_addr = ^bus_addr_i[1:0];

   assign lane_mask = {{8{bus_be_i[3]}}, {8{bus_be_i[2]}}, {8{bus_be_i[1]}}, {8{bus_be_i[0]}}};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [31:0] mask);
      return (old & ~mask) | (wdata & mask);
   endfunction

   // Prescaler wrap is the only point where mtime advances.
   assign tick = timer_en && (presc == CW'(MTIME_DIV - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc <= '0;
      end else if (timer_en) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   // A software write to either half suppresses the increment, so no carry leaks across halves.
   always_comb begin
      mtime_nxt = mtime;
      if (wr && (offset == 6'h00 || offset == 6'h01)) begin
         if (offset == 6'h00) mtime_nxt[31:0]  = merge(mtime[31:0], bus_wdata_i, lane_mask);
         if (offset == 6'h01) mtime_nxt[63:32] = merge(mtime[63:32], bus_wdata_i, lane_mask);
      end else if (tick) begin
         mtime_nxt = mtime + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime <= '0;
      end else begin
         mtime <= mtime_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtimecmp <= '1;
      end else if (wr) begin
         if (offset == 6'h02) mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus_wdata_i, lane_mask);
         if (offset == 6'h03) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus_wdata_i, lane_mask);
      end
   end

   assign enable_w = merge(32'(enable), bus_wdata_i, lane_mask);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         msip     <= 1'b0;
         timer_en <= 1'b0;
         enable   <= '0;
      end else if (wr) begin
         if (offset == 6'h04 && bus_be_i[0]) msip     <= bus_wdata_i[0];
         if (offset == 6'h07 && bus_be_i[0]) timer_en <= bus_wdata_i[0];
         if (offset == 6'h06)                enable   <= enable_w[N-1:0];
      end
   end

   always_comb begin
      ack_mask = '0;
      for (int k = 0; k < int'(N); k++) begin
         if (irq_ack_i && irq_id_i == 5'(16 + k)) ack_mask[k] = 1'b1;
      end
   end

   // Set beats clear: an edge arriving with an ack or W1C must not be lost.
   always_comb begin
      edge_set = ext_irq_i & ~prev;
      clr      = ack_mask;
      if (wr && offset == 6'h05) clr = clr | N'(bus_wdata_i & lane_mask);
      pending_nxt = (pending & ~clr) | edge_set;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev    <= '0;
         pending <= '0;
      end else begin
         prev    <= ext_irq_i;
         pending <= pending_nxt;
      end
   end

   always_comb begin
      bus_rdata_o = '0;
      if (bus_hit_o) begin
         case (offset)
            6'h00:   bus_rdata_o = mtime[31:0];
            6'h01:   bus_rdata_o = mtime[63:32];
            6'h02:   bus_rdata_o = mtimecmp[31:0];
            6'h03:   bus_rdata_o = mtimecmp[63:32];
            6'h04:   bus_rdata_o = {31'b0, msip};
            6'h05:   bus_rdata_o = 32'(pending);
            6'h06:   bus_rdata_o = 32'(enable);
            6'h07:   bus_rdata_o = {31'b0, timer_en};
            default: bus_rdata_o = '0;
         endcase
      end
   end

   always_comb begin
      irq_o           = '0;
      irq_o[3]        = msip;
      irq_o[7]        = (mtime >= mtimecmp);
      irq_o[16 +: N]  = pending & enable;
   end

endmodule

// File: tb/tb_cv32e40p_irq_timer.sv
// tb/tb_cv32e40p_irq_timer.sv - scoreboard bench for cv32e40p_irq_timer
// Stimulus queues expected values; a negedge monitor pops and compares on each probe.
module tb_cv32e40p_irq_timer;

   localparam logic [31:0] B = 32'h1A10_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic [15:0] ext;
   logic [31:0] irq;
   logic        ack;
   logic [4:0]  id;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mask_q[$];
   int          kind_q[$];
   string       name_q[$];
   logic        probe = 1'b0;

   always #5 clk = ~clk;

   cv32e40p_irq_timer #(.BASE_ADDR(B), .NUM_EXT_IRQ(16), .MTIME_DIV(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus_addr_i(addr), .bus_we_i(we), .bus_be_i(be),
      .bus_wdata_i(wdata), .bus_rdata_o(rdata), .bus_hit_o(hit), .ext_irq_i(ext),
      .irq_o(irq), .irq_ack_i(ack), .irq_id_i(id)
   );

   always @(negedge clk) begin
      if (probe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL probe: scoreboard empty at %0t", $time);
         end else begin
            logic [31:0] e, m, a;
            int          k;
            string       n;
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            k = kind_q.pop_front();
            n = name_q.pop_front();
            a = (k == 0) ? rdata : (k == 1) ? irq : {31'b0, hit};
            a = a & m;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h", n, a, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic expect_val(input int k, input logic [31:0] m, input logic [31:0] e, input string n);
      exp_q.push_back(e & m);
      mask_q.push_back(m);
      kind_q.push_back(k);
      name_q.push_back(n);
      probe = 1'b1;
      step();
      probe = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
      addr = a;
      expect_val(0, 32'hFFFF_FFFF, e, n);
   endtask

   task automatic irq_bit(input int b, input logic v, input string n);
      logic [31:0] m;
      m = 32'd1 << b;
      expect_val(1, m, v ? m : 32'd0, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rst_vals [8];
      rst_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      rst_n = 1'b0; addr = B; we = 1'b0; be = 4'h0; wdata = '0; ext = '0; ack = 1'b0; id = '0;
      step(); step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) rd(B + 32'(4 * i), rst_vals[i], $sformatf("reset_reg_%0d", i));
      expect_val(1, 32'hFFFF_FFFF, 32'h0, "reset_irq");
      rd(B + 32'h40, 32'h0, "unimpl_0x40");
      addr = B + 32'h40;           expect_val(2, 32'h1, 32'h1, "hit_in_window");
      addr = B + 32'h0001_0000;    expect_val(2, 32'h1, 32'h0, "hit_outside");
      rd(B + 32'h0001_0000, 32'h0, "rdata_outside");

      // mtime carry into HI and compare
      wr(B + 32'h00, 32'hFFFF_FFFE, 4'hF);
      wr(B + 32'h08, 32'h0, 4'hF);
      wr(B + 32'h0C, 32'h1, 4'hF);
      wr(B + 32'h1C, 32'h1, 4'hF);
      rd(B + 32'h04, 32'h0, "mtime_hi_before_carry");
      rd(B + 32'h00, 32'hFFFF_FFFF, "mtime_lo_max");
      rd(B + 32'h04, 32'h1, "mtime_hi_after_carry");
      irq_bit(7, 1'b1, "mtip_set");
      wr(B + 32'h1C, 32'h0, 4'hF);
      wr(B + 32'h0C, 32'h2, 4'hF);
      irq_bit(7, 1'b0, "mtip_clear_cmp_hi2");

      // byte-enable writes with the timer stopped
      wr(B + 32'h00, 32'h0, 4'hF);
      wr(B + 32'h00, 32'h0000_AB00, 4'b0010);
      rd(B + 32'h00, 32'h0000_AB00, "be_lane1");
      wr(B + 32'h00, 32'h5566_7788, 4'b1000);
      rd(B + 32'h00, 32'h5500_AB00, "be_lane3");

      // edge capture, enable and ack
      ext[2] = 1'b1; step(); ext[2] = 1'b0;
      rd(B + 32'h14, 32'h4, "pending_edge2");
      irq_bit(18, 1'b0, "irq18_masked");
      wr(B + 32'h18, 32'h4, 4'hF);
      irq_bit(18, 1'b1, "irq18_enabled");
      ack = 1'b1; id = 5'd18; step(); ack = 1'b0;
      rd(B + 32'h14, 32'h0, "pending_after_ack18");
      irq_bit(18, 1'b0, "irq18_after_ack");

      // set wins over ack and W1C in the same cycle
      ext[0] = 1'b1; step(); ext[0] = 1'b0;
      rd(B + 32'h14, 32'h1, "pending_edge0");
      step();
      ext[0] = 1'b1; ack = 1'b1; id = 5'd16;
      wr(B + 32'h14, 32'h1, 4'hF);
      ack = 1'b0;
      rd(B + 32'h14, 32'h1, "set_wins_over_clear");
      ext[0] = 1'b0;
      wr(B + 32'h18, 32'h5, 4'hF);
      irq_bit(16, 1'b1, "irq16_enabled");
      ack = 1'b1; id = 5'd7; step(); ack = 1'b0;
      rd(B + 32'h14, 32'h1, "ack7_no_effect");
      irq_bit(16, 1'b1, "irq16_after_ack7");
      wr(B + 32'h14, 32'h1, 4'hF);
      rd(B + 32'h14, 32'h0, "w1c_clear");

      // MSIP and reset mid-count
      wr(B + 32'h10, 32'h1, 4'hF);
      irq_bit(3, 1'b1, "msip_irq");
      ext[1] = 1'b1; step(); ext[1] = 1'b0;
      wr(B + 32'h1C, 32'h1, 4'hF);
      step(); step(); step();
      rst_n = 1'b0;
      expect_val(1, 32'hFFFF_FFFF, 32'h0, "irq_in_reset");
      rst_n = 1'b1;
      step(); step();
      rd(B + 32'h00, 32'h0, "mtime_lo_after_reset");
      rd(B + 32'h04, 32'h0, "mtime_hi_after_reset");
      rd(B + 32'h14, 32'h0, "pending_after_reset");
      rd(B + 32'h1C, 32'h0, "ctrl_after_reset");
      rd(B + 32'h00, 32'h0, "mtime_holds");

      step();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
